// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI command sequencer: frames a 6-byte command, polls for R1 and
// optionally releases chip-select with a trailing 0xFF byte.
module sd_cmd_sequencer #(
  parameter logic [12:0] NCR_MAX = 13'd8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  input  logic [6:0]  crc,
  input  logic        hold_cs,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        cs_n,
  output logic [1:0]  sh_mode,
  output logic [7:0]  sh_data_in,
  output logic        sh_wr_req,
  output logic        sh_rd_req,
  output logic [12:0] sh_new_rx_length,
  output logic        sh_set_rx_length,
  input  logic [7:0]  sh_data_out,
  input  logic        sh_in_full,
  input  logic        sh_out_full,
  input  logic        sh_busy
);

  localparam logic [1:0] MODE_STOP = 2'd0;
  localparam logic [1:0] MODE_RX   = 2'd1;
  localparam logic [1:0] MODE_TX   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_CMD_TX      = 4'd1,
    S_TX_DRAIN    = 4'd2,
    S_RX_ARM      = 4'd3,
    S_RX_POLL     = 4'd4,
    S_RX_STOP     = 4'd5,
    S_TRAIL_TX    = 4'd6,
    S_TRAIL_DRAIN = 4'd7,
    S_DONE        = 4'd8
  } state_t;

  state_t      r_state;
  logic [47:0] r_frame;
  logic [2:0]  r_byte_idx;
  logic        r_hold_cs;
  logic [12:0] r_poll_cnt;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_r1;
  logic        r_timeout;
  logic        r_cs_n;
  logic [1:0]  r_sh_mode;
  logic [12:0] r_new_rx_len;
  logic        r_set_rx_len;
  logic        w_wr_req;
  logic        w_rd_req;

  function automatic logic [47:0] build_frame(input logic [5:0] f_cmd,
                                              input logic [31:0] f_arg,
                                              input logic [6:0] f_crc);
    return {2'b01, f_cmd, f_arg, f_crc, 1'b1};
  endfunction

  // Transfer requests only when the shifter can take or give a byte this cycle.
  always_comb begin
    w_wr_req = 1'b0;
    w_rd_req = 1'b0;
    case (r_state)
      S_CMD_TX, S_TRAIL_TX: w_wr_req = !sh_in_full;
      S_RX_POLL, S_RX_STOP: w_rd_req = sh_out_full;
      default: begin
        w_wr_req = 1'b0;
        w_rd_req = 1'b0;
      end
    endcase
  end

  // Transaction FSM; mode, strobes and flags are updated on each transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_frame      <= 48'hFFFF_FFFF_FFFF;
      r_byte_idx   <= 3'd0;
      r_hold_cs    <= 1'b0;
      r_poll_cnt   <= 13'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_r1         <= 8'hFF;
      r_timeout    <= 1'b0;
      r_cs_n       <= 1'b1;
      r_sh_mode    <= MODE_STOP;
      r_new_rx_len <= 13'd0;
      r_set_rx_len <= 1'b0;
    end else begin
      r_set_rx_len <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_frame    <= build_frame(cmd, arg, crc);
            r_hold_cs  <= hold_cs;
            r_byte_idx <= 3'd0;
            r_busy     <= 1'b1;
            r_timeout  <= 1'b0;
            r_cs_n     <= 1'b0;
            r_sh_mode  <= MODE_TX;
            r_state    <= S_CMD_TX;
          end
        end
        S_CMD_TX: begin
          // Shifting in 0xFF leaves the trailing byte ready in r_frame.
          if (w_wr_req) begin
            r_frame <= {r_frame[39:0], 8'hFF};
            if (r_byte_idx == 3'd5) begin
              r_state <= S_TX_DRAIN;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end
        end
        S_TX_DRAIN: begin
          if (!sh_in_full && !sh_busy) begin
            r_sh_mode    <= MODE_STOP;
            r_new_rx_len <= NCR_MAX;
            r_set_rx_len <= 1'b1;
            r_poll_cnt   <= 13'd0;
            r_state      <= S_RX_ARM;
          end
        end
        S_RX_ARM: begin
          r_sh_mode <= MODE_RX;
          r_state   <= S_RX_POLL;
        end
        S_RX_POLL: begin
          if (w_rd_req) begin
            r_poll_cnt <= r_poll_cnt + 13'd1;
            if (!sh_data_out[7]) begin
              r_r1      <= sh_data_out;
              r_sh_mode <= MODE_STOP;
              r_state   <= S_RX_STOP;
            end else if ((r_poll_cnt + 13'd1) >= NCR_MAX) begin
              r_r1      <= 8'hFF;
              r_timeout <= 1'b1;
              r_sh_mode <= MODE_STOP;
              r_state   <= S_RX_STOP;
            end
          end
        end
        S_RX_STOP: begin
          if (!sh_busy && !sh_out_full) begin
            r_new_rx_len <= 13'd0;
            r_set_rx_len <= 1'b1;
            if (!r_hold_cs) begin
              r_cs_n    <= 1'b1;
              r_sh_mode <= MODE_TX;
              r_state   <= S_TRAIL_TX;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_TRAIL_TX: begin
          if (w_wr_req) begin
            r_state <= S_TRAIL_DRAIN;
          end
        end
        S_TRAIL_DRAIN: begin
          if (!sh_in_full && !sh_busy) begin
            r_sh_mode <= MODE_STOP;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_sh_mode <= MODE_STOP;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign r1               = r_r1;
  assign timeout          = r_timeout;
  assign cs_n             = r_cs_n;
  assign sh_mode          = r_sh_mode;
  assign sh_data_in       = r_frame[47:40];
  assign sh_wr_req        = w_wr_req;
  assign sh_rd_req        = w_rd_req;
  assign sh_new_rx_length = r_new_rx_len;
  assign sh_set_rx_length = r_set_rx_len;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: behavioural byte shifter plus card MISO queue,
// with MOSI bytes and per-transaction results checked against scoreboards.
module tb_sd_cmd_sequencer;

  localparam int BYTE_CYC = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [6:0]  crc;
  logic        hold_cs;
  logic        busy, done, timeout, cs_n;
  logic [7:0]  r1;
  logic [1:0]  sh_mode;
  logic [7:0]  sh_data_in;
  logic        sh_wr_req, sh_rd_req, sh_set_rx_length;
  logic [12:0] sh_new_rx_length;
  logic [7:0]  sh_data_out;
  logic        sh_in_full, sh_out_full, sh_busy;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.NCR_MAX(13'd8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .arg(arg),
    .crc(crc), .hold_cs(hold_cs), .busy(busy), .done(done), .r1(r1),
    .timeout(timeout), .cs_n(cs_n), .sh_mode(sh_mode), .sh_data_in(sh_data_in),
    .sh_wr_req(sh_wr_req), .sh_rd_req(sh_rd_req),
    .sh_new_rx_length(sh_new_rx_length), .sh_set_rx_length(sh_set_rx_length),
    .sh_data_out(sh_data_out), .sh_in_full(sh_in_full),
    .sh_out_full(sh_out_full), .sh_busy(sh_busy)
  );

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        hold;
    int          n_ff;
    logic        has_resp;
    logic [7:0]  resp;
    logic [47:0] exp_frame;
    logic [7:0]  exp_r1;
    logic        exp_to;
    int          exp_polls;
  } vec_t;

  typedef struct { logic [7:0] b; logic cs; } mosi_t;
  typedef struct { logic [7:0] r1; logic to; int polls; logic cs_n; } res_t;

  vec_t       vecs[5];
  mosi_t      mosi_q[$];
  res_t       res_q[$];
  logic [7:0] miso_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int poll_cnt = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural shifter: one input buffer, one output buffer, BYTE_CYC per byte.
  logic        m_in_full, m_out_full, m_busy, m_rx;
  logic [7:0]  m_in_byte, m_out_byte;
  int          m_cnt;
  logic [12:0] m_rx_len;

  assign sh_in_full  = m_in_full;
  assign sh_out_full = m_out_full;
  assign sh_busy     = m_busy;
  assign sh_data_out = m_out_byte;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_in_full <= 1'b0; m_out_full <= 1'b0; m_busy <= 1'b0; m_rx <= 1'b0;
      m_in_byte <= 8'hFF; m_out_byte <= 8'hFF; m_cnt <= 0; m_rx_len <= 13'd0;
    end else begin
      if (sh_set_rx_length) m_rx_len <= sh_new_rx_length;
      if (sh_rd_req) m_out_full <= 1'b0;
      if (sh_wr_req) begin
        m_in_full <= 1'b1;
        m_in_byte <= sh_data_in;
      end
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          if (m_rx) begin
            m_out_full <= 1'b1;
            if (miso_q.size() > 0) m_out_byte <= miso_q.pop_front();
            else m_out_byte <= 8'hFF;
          end
        end
      end else if (sh_mode == 2'd2 && m_in_full) begin
        m_busy <= 1'b1; m_cnt <= BYTE_CYC; m_rx <= 1'b0; m_in_full <= 1'b0;
      end else if (sh_mode == 2'd1 && m_rx_len != 13'd0 && !m_out_full) begin
        m_busy <= 1'b1; m_cnt <= BYTE_CYC; m_rx <= 1'b1; m_rx_len <= m_rx_len - 13'd1;
      end
    end
  end

  // Monitor on the falling edge: MOSI bytes as they start shifting, polls, done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!m_busy && sh_mode == 2'd2 && m_in_full) begin
        check("mosi_expected", (mosi_q.size() > 0), 1);
        if (mosi_q.size() > 0) begin
          check("mosi_byte", m_in_byte, mosi_q[0].b);
          check("mosi_cs_n", cs_n, mosi_q[0].cs);
          void'(mosi_q.pop_front());
        end
      end
      if (sh_set_rx_length)
        check("set_rx_len_shifter_idle", {m_busy, m_in_full, m_out_full}, 0);
      if (sh_rd_req && sh_mode == 2'd1) poll_cnt++;
      if (done) begin
        done_cnt++;
        check("result_expected", (res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
          check("r1", r1, res_q[0].r1);
          check("timeout", timeout, res_q[0].to);
          check("poll_bytes", poll_cnt, res_q[0].polls);
          check("cs_n_at_done", cs_n, res_q[0].cs_n);
          check("busy_at_done", busy, 1);
          check("mosi_all_sent", mosi_q.size(), 0);
          void'(res_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_r1"}, r1, 8'hFF);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_sh_mode"}, sh_mode, 0);
    check({tag, "_wr_req"}, sh_wr_req, 0);
    check({tag, "_rd_req"}, sh_rd_req, 0);
    check({tag, "_set_rx"}, sh_set_rx_length, 0);
    check({tag, "_data_in"}, sh_data_in, 8'hFF);
    check({tag, "_new_rx_len"}, sh_new_rx_length, 0);
  endtask

  task automatic load_txn(input vec_t v);
    mosi_t m;
    res_t  r;
    miso_q.delete();
    mosi_q.delete();
    res_q.delete();
    for (int i = 0; i < v.n_ff; i++) miso_q.push_back(8'hFF);
    if (v.has_resp) miso_q.push_back(v.resp);
    for (int i = 0; i < 6; i++) begin
      m.b  = v.exp_frame[47-8*i -: 8];
      m.cs = 1'b0;
      mosi_q.push_back(m);
    end
    if (!v.hold) begin
      m.b = 8'hFF; m.cs = 1'b1;
      mosi_q.push_back(m);
    end
    r.r1 = v.exp_r1; r.to = v.exp_to; r.polls = v.exp_polls; r.cs_n = !v.hold;
    res_q.push_back(r);
    done_cnt = 0;
    poll_cnt = 0;
    start = 1'b1; cmd = v.cmd; arg = v.arg; crc = v.crc; hold_cs = v.hold;
    @(negedge clk);
    start = 1'b0; cmd = 6'h00; arg = 32'h0; crc = 7'h00; hold_cs = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_txn(input vec_t v, input bit extra_start);
    load_txn(v);
    for (int c = 0; c < 3000; c++) begin
      if (done_cnt != 0) break;
      if (extra_start && c == 3) begin
        check("mode_tx_at_extra_start", sh_mode, 2'd2);
        start = 1'b1; cmd = 6'h3F; arg = 32'hDEADBEEF; crc = 7'h11; hold_cs = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check("done_seen", done_cnt, 1);
    repeat (3) @(negedge clk);
    check("done_single", done_cnt, 1);
    check("done_low_after", done, 0);
    check("busy_low_after", busy, 0);
    check("cs_n_after", cs_n, !v.hold);
    check("r1_held", r1, v.exp_r1);
    check("timeout_held", timeout, v.exp_to);
  endtask

  initial begin
    vecs[0] = '{6'h00, 32'h0000_0000, 7'h4A, 1'b0, 1, 1'b1, 8'h01,
                48'h40_00_00_00_00_95, 8'h01, 1'b0, 2};
    vecs[1] = '{6'h08, 32'h0000_01AA, 7'h43, 1'b1, 2, 1'b1, 8'h01,
                48'h48_00_00_01_AA_87, 8'h01, 1'b0, 3};
    vecs[2] = '{6'h11, 32'h1234_5678, 7'h2A, 1'b0, 0, 1'b0, 8'h00,
                48'h51_12_34_56_78_55, 8'hFF, 1'b1, 8};
    vecs[3] = '{6'h37, 32'h0000_0000, 7'h32, 1'b0, 7, 1'b1, 8'h00,
                48'h77_00_00_00_00_65, 8'h00, 1'b0, 8};
    vecs[4] = '{6'h3F, 32'hFFFF_FFFF, 7'h7F, 1'b0, 0, 1'b1, 8'h05,
                48'h7F_FF_FF_FF_FF_FF, 8'h05, 1'b0, 1};

    reset_n = 1'b0; start = 1'b0; cmd = 6'h00; arg = 32'h0; crc = 7'h00; hold_cs = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (i > 0 && vecs[i-1].hold) check("cs_n_held_between", cs_n, 0);
      run_txn(vecs[i], 1'b0);
    end

    // Start pulsed mid-command must not disturb the running transaction.
    run_txn(vecs[0], 1'b1);
    repeat (5) @(negedge clk);
    check("no_extra_txn_busy", busy, 0);
    check("no_extra_txn_done", done_cnt, 1);

    // Asynchronous reset in the middle of response polling.
    load_txn(vecs[2]);
    for (int c = 0; c < 500; c++) begin
      if (sh_mode == 2'd1) break;
      @(negedge clk);
    end
    check("reached_rx_poll", sh_mode, 2'd1);
    repeat (12) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    mosi_q.delete();
    res_q.delete();
    miso_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(vecs[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
